// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// PC source encodings, controller FSM states and a bubble-count helper.
package hazard_stall_unit_pkg;

    // PC source encodings decoded in ID
    localparam logic [2:0] PCSRC_PC4  = 3'b000;
    localparam logic [2:0] PCSRC_BR   = 3'b001;
    localparam logic [2:0] PCSRC_J    = 3'b010;
    localparam logic [2:0] PCSRC_JREG = 3'b011;

    // Controller states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } stateT;

    // Bubble counts produced by the hazard compare
    localparam logic [1:0] BUBBLE_NONE = 2'd0;
    localparam logic [1:0] BUBBLE_ONE  = 2'd1;
    localparam logic [1:0] BUBBLE_TWO  = 2'd2;

    // Several hazards may match at once; the longest one dominates.
    function automatic logic [1:0] bubbleMax(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_hazard_detect.sv
// Pure combinational dependency compare for the instruction in ID.
// Reports how many bubbles are needed before forwarding can cover it.
module hazard_detect
    import hazard_stall_unit_pkg::*;
#(
    parameter logic [2:0] PCSRC_JR = PCSRC_JREG
) (
    input  logic [4:0] IF_ID_InstRs,
    input  logic [4:0] IF_ID_InstRt,
    input  logic       ID_UsesRt,
    input  logic [2:0] ID_PCSrc,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_RegWrite,
    input  logic [4:0] ID_EX_RegWriteAddr,
    input  logic       EX_MEM_MemRead,
    input  logic       EX_MEM_RegWrite,
    input  logic [4:0] EX_MEM_RegWriteAddr,
    output logic [1:0] bubbleCount
);

    logic isJr;
    logic exLoad;
    logic memLoad;
    logic luHit;
    logic jr1Hit;
    logic jr2Hit;

    // Loads writing $0 never create a real dependency.
    assign isJr    = (ID_PCSrc == PCSRC_JR);
    assign exLoad  = ID_EX_MemRead & ID_EX_RegWrite & (ID_EX_RegWriteAddr != 5'd0);
    assign memLoad = EX_MEM_MemRead & EX_MEM_RegWrite & (EX_MEM_RegWriteAddr != 5'd0);

    // Load in EX feeding an ALU source: data arrives one cycle too late.
    assign luHit  = exLoad & ((ID_EX_RegWriteAddr == IF_ID_InstRs) |
                              (ID_UsesRt & (ID_EX_RegWriteAddr == IF_ID_InstRt)));
    // jr resolves its target in ID, so a load still in EX costs two cycles,
    // one in MEM costs one. ALU producers are forwarded and cost nothing.
    assign jr1Hit = isJr & exLoad  & (ID_EX_RegWriteAddr  == IF_ID_InstRs);
    assign jr2Hit = isJr & memLoad & (EX_MEM_RegWriteAddr == IF_ID_InstRs);

    // Pick the longest stall among the matching cases.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        bubbleCount = BUBBLE_NONE;
        if (luHit)  bubbleCount = bubbleMax(bubbleCount, BUBBLE_ONE);
        if (jr2Hit) bubbleCount = bubbleMax(bubbleCount, BUBBLE_ONE);
        if (jr1Hit) bubbleCount = bubbleMax(bubbleCount, BUBBLE_TWO);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: inserts bubbles where
// forwarding cannot help, flushes on taken branches and exceptions, and
// counts bubble cycles in a saturating performance counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [2:0] PCSRC_JR = PCSRC_JREG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_InstRs,
    input  logic [4:0]       IF_ID_InstRt,
    input  logic             ID_UsesRt,
    input  logic [2:0]       ID_PCSrc,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegWriteAddr,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_RegWrite,
    input  logic [4:0]       EX_MEM_RegWriteAddr,
    input  logic             EX_BranchTaken,
    input  logic             Exception,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic [CNT_W-1:0] StallCycles
);

    stateT      state;
    logic [1:0] remaining;
    logic [1:0] bubbleCount;

    hazard_detect #(.PCSRC_JR(PCSRC_JR)) detect (
        .IF_ID_InstRs        (IF_ID_InstRs),
        .IF_ID_InstRt        (IF_ID_InstRt),
        .ID_UsesRt           (ID_UsesRt),
        .ID_PCSrc            (ID_PCSrc),
        .ID_EX_MemRead       (ID_EX_MemRead),
        .ID_EX_RegWrite      (ID_EX_RegWrite),
        .ID_EX_RegWriteAddr  (ID_EX_RegWriteAddr),
        .EX_MEM_MemRead      (EX_MEM_MemRead),
        .EX_MEM_RegWrite     (EX_MEM_RegWrite),
        .EX_MEM_RegWriteAddr (EX_MEM_RegWriteAddr),
        .bubbleCount         (bubbleCount)
    );

    // Control outputs, resolved by priority: reset > exception > flush > branch > stall > run.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (!reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (Exception) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (state == FLUSH) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if ((state == STALL) || (bubbleCount != BUBBLE_NONE)) begin
            // Freeze PC and IF_ID, push a bubble into EX.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    // FSM, remaining-bubble counter and saturating stall counter.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state       <= RUN;
            remaining   <= 2'd0;
            StallCycles <= '0;
        end else begin
            if (Exception) begin
                state     <= FLUSH;
                remaining <= 2'd0;
            end else begin
                case (state)
                    FLUSH: begin
                        state     <= RUN;
                        remaining <= 2'd0;
                    end
                    STALL: begin
                        if (EX_BranchTaken) begin
                            state     <= RUN;
                            remaining <= 2'd0;
                        end else begin
                            remaining <= remaining - 2'd1;
                            if (remaining <= 2'd1) state <= RUN;
                        end
                    end
                    default: begin
                        if (EX_BranchTaken) begin
                            state     <= RUN;
                            remaining <= 2'd0;
                        end else if (bubbleCount != BUBBLE_NONE) begin
                            remaining <= bubbleCount - 2'd1;
                            state     <= (bubbleCount > BUBBLE_ONE) ? STALL : RUN;
                        end else begin
                            state     <= RUN;
                            remaining <= 2'd0;
                        end
                    end
                endcase
            end
            if (!PC_Write && (StallCycles != {CNT_W{1'b1}})) begin
                StallCycles <= StallCycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a 4-bit stall counter so
// saturation is reachable. Inputs change 1ns after the rising edge and
// outputs are sampled 2ns after it.
module tb_hazard_stall_unit;

    localparam int CNT_W = 4;
    localparam logic [2:0] JR = 3'b011;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    localparam logic [4:0] CTL_RUN   = 5'b11000;
    localparam logic [4:0] CTL_STALL = 5'b00010;
    localparam logic [4:0] CTL_BR    = 5'b11110;
    localparam logic [4:0] CTL_RST   = 5'b00111;
    // {PC_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    localparam logic [3:0] FL_EXC    = 4'b1111;
    localparam logic [3:0] FL_FLUSH  = 4'b1110;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       IF_ID_InstRs, IF_ID_InstRt;
    logic             ID_UsesRt;
    logic [2:0]       ID_PCSrc;
    logic             ID_EX_MemRead, ID_EX_RegWrite;
    logic [4:0]       ID_EX_RegWriteAddr;
    logic             EX_MEM_MemRead, EX_MEM_RegWrite;
    logic [4:0]       EX_MEM_RegWriteAddr;
    logic             EX_BranchTaken, Exception;
    logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush;
    logic [CNT_W-1:0] StallCycles;

    logic [4:0] ctl;
    logic [3:0] flushCtl;
    assign ctl      = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};
    assign flushCtl = {PC_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};

    int checkCount = 0;
    int errorCount = 0;

    hazard_stall_unit #(.CNT_W(CNT_W), .PCSRC_JR(JR)) dut (
        .clk                 (clk),
        .reset               (reset),
        .IF_ID_InstRs        (IF_ID_InstRs),
        .IF_ID_InstRt        (IF_ID_InstRt),
        .ID_UsesRt           (ID_UsesRt),
        .ID_PCSrc            (ID_PCSrc),
        .ID_EX_MemRead       (ID_EX_MemRead),
        .ID_EX_RegWrite      (ID_EX_RegWrite),
        .ID_EX_RegWriteAddr  (ID_EX_RegWriteAddr),
        .EX_MEM_MemRead      (EX_MEM_MemRead),
        .EX_MEM_RegWrite     (EX_MEM_RegWrite),
        .EX_MEM_RegWriteAddr (EX_MEM_RegWriteAddr),
        .EX_BranchTaken      (EX_BranchTaken),
        .Exception           (Exception),
        .PC_Write            (PC_Write),
        .IF_ID_Write         (IF_ID_Write),
        .IF_ID_Flush         (IF_ID_Flush),
        .ID_EX_Flush         (ID_EX_Flush),
        .EX_MEM_Flush        (EX_MEM_Flush),
        .StallCycles         (StallCycles)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        IF_ID_InstRs        = 5'd0;
        IF_ID_InstRt        = 5'd0;
        ID_UsesRt           = 1'b0;
        ID_PCSrc            = 3'b000;
        ID_EX_MemRead       = 1'b0;
        ID_EX_RegWrite      = 1'b0;
        ID_EX_RegWriteAddr  = 5'd0;
        EX_MEM_MemRead      = 1'b0;
        EX_MEM_RegWrite     = 1'b0;
        EX_MEM_RegWriteAddr = 5'd0;
        EX_BranchTaken      = 1'b0;
        Exception           = 1'b0;
    endtask

    task automatic loadInEx(input logic [4:0] dest);
        ID_EX_MemRead      = 1'b1;
        ID_EX_RegWrite     = 1'b1;
        ID_EX_RegWriteAddr = dest;
    endtask

    // lw $31 in EX with jr $31 in ID
    task automatic setJr1();
        setIdle();
        loadInEx(5'd31);
        ID_PCSrc     = JR;
        IF_ID_InstRs = 5'd31;
    endtask

    initial begin
        reset = 1'b0;
        setIdle();

        // Reset state
        tick(); #1;
        checkVal("reset_ctl", ctl, CTL_RST);
        checkVal("reset_cnt", StallCycles, 0);

        tick(); reset = 1'b1; #1;
        checkVal("run_default", ctl, CTL_RUN);

        // Load-use through rs
        tick(); setIdle(); loadInEx(5'd8); IF_ID_InstRs = 5'd8; IF_ID_InstRt = 5'd9; #1;
        checkVal("lu_rs_stall", ctl, CTL_STALL);
        tick(); setIdle(); #1;
        checkVal("lu_rs_after", ctl, CTL_RUN);
        checkVal("lu_rs_cnt", StallCycles, 1);

        // Load-use through rt, honoured only when rt is a source
        tick(); setIdle(); loadInEx(5'd8); IF_ID_InstRs = 5'd4; IF_ID_InstRt = 5'd8; ID_UsesRt = 1'b1; #1;
        checkVal("lu_rt_stall", ctl, CTL_STALL);
        tick(); setIdle(); #1;
        checkVal("lu_rt_cnt", StallCycles, 2);
        tick(); setIdle(); loadInEx(5'd8); IF_ID_InstRs = 5'd4; IF_ID_InstRt = 5'd8; ID_UsesRt = 1'b0; #1;
        checkVal("rt_unused", ctl, CTL_RUN);
        tick(); setIdle(); #1;
        checkVal("rt_unused_cnt", StallCycles, 2);

        // jr on a load in EX: two bubbles
        tick(); setJr1(); #1;
        checkVal("jr1_first", ctl, CTL_STALL);
        tick(); setIdle(); EX_MEM_MemRead = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_RegWriteAddr = 5'd31;
        ID_PCSrc = JR; IF_ID_InstRs = 5'd31; #1;
        checkVal("jr1_second", ctl, CTL_STALL);
        checkVal("jr1_cnt_mid", StallCycles, 3);
        tick(); setIdle(); ID_PCSrc = JR; IF_ID_InstRs = 5'd31; #1;
        checkVal("jr1_done", ctl, CTL_RUN);
        checkVal("jr1_cnt", StallCycles, 4);

        // jr on a load in MEM: one bubble
        tick(); setIdle(); EX_MEM_MemRead = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_RegWriteAddr = 5'd31;
        ID_PCSrc = JR; IF_ID_InstRs = 5'd31; #1;
        checkVal("jr2_stall", ctl, CTL_STALL);
        tick(); setIdle(); #1;
        checkVal("jr2_done", ctl, CTL_RUN);
        checkVal("jr2_cnt", StallCycles, 5);

        // jr on an ALU producer: forwarded
        tick(); setIdle(); ID_EX_RegWrite = 1'b1; ID_EX_RegWriteAddr = 5'd31; ID_PCSrc = JR; IF_ID_InstRs = 5'd31; #1;
        checkVal("jr_alu", ctl, CTL_RUN);

        // Load to $0 is never a hazard
        tick(); setIdle(); loadInEx(5'd0); IF_ID_InstRs = 5'd0; IF_ID_InstRt = 5'd0; ID_UsesRt = 1'b1; #1;
        checkVal("lw_zero", ctl, CTL_RUN);
        tick(); setIdle(); #1;
        checkVal("no_stall_cnt", StallCycles, 5);

        // Branch taken on the cycle a jr stall would start
        tick(); setJr1(); EX_BranchTaken = 1'b1; #1;
        checkVal("br_over_jr1", ctl, CTL_BR);
        tick(); setIdle(); #1;
        checkVal("br_run_next", ctl, CTL_RUN);
        checkVal("br_cnt", StallCycles, 5);

        // Branch taken while in STALL
        tick(); setJr1(); #1;
        checkVal("br_stall_in", ctl, CTL_STALL);
        tick(); setIdle(); EX_BranchTaken = 1'b1; #1;
        checkVal("br_in_stall", ctl, CTL_BR);
        tick(); setIdle(); #1;
        checkVal("br_stall_run", ctl, CTL_RUN);
        checkVal("br_stall_cnt", StallCycles, 6);

        // Exception during STALL, then one FLUSH cycle, then RUN
        tick(); setJr1(); #1;
        checkVal("exc_stall_in", ctl, CTL_STALL);
        tick(); setIdle(); Exception = 1'b1; #1;
        checkVal("exc_flush_all", flushCtl, FL_EXC);
        tick(); setIdle(); #1;
        checkVal("exc_flush_state", flushCtl, FL_FLUSH);
        checkVal("exc_cnt", StallCycles, 7);
        tick(); setIdle(); #1;
        checkVal("exc_run", ctl, CTL_RUN);

        // Exception arriving in FLUSH re-enters FLUSH
        tick(); setIdle(); Exception = 1'b1; #1;
        checkVal("exc2_first", flushCtl, FL_EXC);
        tick(); Exception = 1'b1; #1;
        checkVal("exc2_in_flush", flushCtl, FL_EXC);
        tick(); setIdle(); #1;
        checkVal("exc2_flush", flushCtl, FL_FLUSH);
        tick(); setIdle(); #1;
        checkVal("exc2_run", ctl, CTL_RUN);

        // Continuous jr hazard until the 4-bit counter saturates
        tick(); setJr1(); #1;
        checkVal("sat_start", ctl, CTL_STALL);
        for (int i = 1; i <= 11; i++) begin
            tick(); #1;
            checkVal($sformatf("sat_ctl_%0d", i), ctl, CTL_STALL);
            checkVal($sformatf("sat_cnt_%0d", i), StallCycles, (7 + i > 15) ? 15 : 7 + i);
        end

        // Reset asserted mid-STALL
        reset = 1'b0; #1;
        checkVal("rst_mid_ctl", ctl, CTL_RST);
        tick(); #1;
        checkVal("rst_mid_cnt", StallCycles, 0);
        checkVal("rst_mid_ctl2", ctl, CTL_RST);
        setIdle(); reset = 1'b1; #1;
        checkVal("rst_mid_run", ctl, CTL_RUN);
        tick(); #1;
        checkVal("rst_mid_cnt2", StallCycles, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
